// File: rtl/instr_fetch_mem.sv
// Loadable byte-addressed instruction memory with a req/valid/ack fetch handshake.
// Optional alignment checking is enabled by defining IMEM_ALIGN_CHECK_EN.
module instr_fetch_mem #(
    parameter int ADDR_W          = 8,
    parameter int BYTES_PER_INSTR = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_en,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [7:0]                   ld_data,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_ready,
    output logic                         instr_valid,
    output logic [8*BYTES_PER_INSTR-1:0] instr,
    input  logic                         instr_ack,
    output logic                         fetch_err
);

    localparam int IW    = 8 * BYTES_PER_INSTR;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          mem_r [DEPTH];
    logic [IW-1:0]       word_s;
    logic [IW-1:0]       instr_next_s;
    logic                err_next_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: state_next_s = ST_PRESENT;
            ST_PRESENT: begin
                if (instr_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PRESENT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        fetch_ready = 1'b0;
        instr_valid = 1'b0;
        case (state_r)
            ST_IDLE:    fetch_ready = 1'b1;
            ST_READ:    fetch_ready = 1'b0;
            ST_PRESENT: instr_valid = 1'b1;
            default:    fetch_ready = 1'b0;
        endcase
    end

    // Fetch address latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if ((state_r == ST_IDLE) && fetch_req) begin
            addr_r <= fetch_addr;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Byte load port; the array is deliberately outside reset so programs survive it
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Big-endian assembly; index arithmetic is ADDR_W wide so it wraps around the array
    always_comb begin
        word_s = {IW{1'b0}};
        for (int b = 0; b < BYTES_PER_INSTR; b++) begin
            word_s[IW-8-8*b +: 8] = mem_r[addr_r + ADDR_W'(b)];
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    logic misalign_s;

    // Misaligned fetches return HALT with the error flag set
    always_comb begin
        misalign_s = (addr_r & ADDR_W'(BYTES_PER_INSTR - 1)) != {ADDR_W{1'b0}};
        if (misalign_s) begin
            instr_next_s = {IW{1'b0}};
            err_next_s   = 1'b1;
        end else begin
            instr_next_s = word_s;
            err_next_s   = 1'b0;
        end
    end
`else
    // Without alignment checking the assembled word passes through unchanged
    always_comb begin
        instr_next_s = word_s;
        err_next_s   = 1'b0;
    end
`endif

    // Result registers; captured on the READ edge (old memory contents) and held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr     <= {IW{1'b0}};
            fetch_err <= 1'b0;
        end else if (state_r == ST_READ) begin
            instr     <= instr_next_s;
            fetch_err <= err_next_s;
        end else begin
            instr     <= instr;
            fetch_err <= fetch_err;
        end
    end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, loadable instruction memory for the fetch stage. It stores a byte-addressed program and returns one multi-byte instruction per fetch through a request/valid/acknowledge handshake. The assembled word is held stable until the consumer acknowledges it. The program is written at boot through a byte-wide load port, not hard-coded at reset.

## Interface
- `ADDR_W`, default 8: byte-address width; memory depth is `2**ADDR_W` bytes.
- `BYTES_PER_INSTR`, default 2: bytes per instruction; must be a power of two, ≥1 and ≤ `2**ADDR_W`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears control state only.
- `ld_en`, input, 1: write `ld_data` to `ld_addr` on this edge.
- `ld_addr`, input, `ADDR_W`: load byte address.
- `ld_data`, input, 8: load byte.
- `fetch_req`, input, 1: fetch request; accepted when `fetch_req & fetch_ready`.
- `fetch_addr`, input, `ADDR_W`: byte address of the instruction's first (most-significant) byte.
- `fetch_ready`, output, 1: high exactly in IDLE.
- `instr_valid`, output, 1: `instr`/`fetch_err` are valid; high exactly in PRESENT.
- `instr`, output, `8*BYTES_PER_INSTR`: assembled instruction, registered.
- `instr_ack`, input, 1: consumer takes the instruction; ignored unless `instr_valid`.
- `fetch_err`, output, 1: misaligned fetch (see Configuration); registered.

## Operation
- Storage: `2**ADDR_W` × 8-bit array, not cleared by `reset`; contents survive reset and are undefined at power-up until loaded.
- FSM states: IDLE → READ → PRESENT → IDLE.
  - IDLE: `fetch_ready`=1. On `fetch_req` at an edge, latch `fetch_addr` → READ.
  - READ: unconditionally → PRESENT. At this edge, `instr` ← {mem[a], mem[a+1], …, mem[a+B-1]}, big-endian (first byte in MSBs). Byte addresses wrap modulo `2**ADDR_W`. `fetch_err` is updated at the same edge.
  - PRESENT: `instr`, `fetch_err` and `instr_valid` are held stable. On `instr_ack` → IDLE. With no ack the state holds indefinitely.
- `fetch_req` outside IDLE is ignored. The requester must re-assert it or hold it.
- Load port: active in every state, one byte per edge.
  - Load and READ to the same byte on the same edge: the READ returns the old byte (read-before-write).
  - Loads during PRESENT never change the held `instr`.
- Reset, asserted any time including mid-fetch:
  - Immediately: state=IDLE, `instr_valid`=0, `instr`=0, `fetch_err`=0, `fetch_ready`=1.
  - The pending fetch is discarded and the latched address is cleared to 0.
- Encoding 0 is the HALT instruction. An all-zero `instr` after reset therefore decodes as HALT.

## Timing
- Request accepted at edge E0, `instr_valid` rises after E1: latency 2 edges.
- `instr_ack` sampled high at edge Ek: `instr_valid` falls and `fetch_ready` rises after Ek. The next request is accepted at the earliest at Ek+1.
- Peak throughput: one instruction per 3 cycles with `instr_ack` tied high.
- All outputs are registered or decoded directly from the state register; no input-to-output combinational path.

## Configuration
- `IMEM_ALIGN_CHECK_EN` defined:
  - At READ, `fetch_addr mod BYTES_PER_INSTR ≠ 0` sets `fetch_err`=1 and forces `instr`=0 (HALT).
  - Aligned fetches give `fetch_err`=0.
  - The handshake is unchanged.
- Not defined:
  - `fetch_err` is constant 0.
  - Misaligned fetches assemble bytes from the given address with modulo wrap.
  - No alignment logic is synthesised.

## Test plan
- Defaults, load mem[0]=0x21, mem[1]=0xFE; fetch 0x00 → `instr_valid` after 2 edges, `instr`=0x21FE, `fetch_err`=0.
- Hold `instr_ack`=0 for 5 cycles while loading mem[0]=0x00 → `instr` stays 0x21FE and `fetch_ready` stays 0. Ack → IDLE next edge.
- Load mem[2]=0x22 while a fetch of 0x02 is in READ (mem[2] was 0x9A, mem[3]=0xFB) → `instr`=0x9AFB. Refetch → 0x22FB.
- Macro undefined: mem[0xFF]=0x58, mem[0x00]=0x23; fetch 0xFF → `instr`=0x5823, `fetch_err`=0.
- Macro defined: fetch 0x03 → `fetch_err`=1, `instr`=0x0000, `instr_valid`=1 until ack.
- Assert `reset` during PRESENT holding 0x21FE → outputs 0 and `fetch_ready`=1 immediately. After release, fetch 0x00 returns 0x21FE (memory preserved).
